// File: rtl/rtc_pkg.sv
// Shared constants, state encodings and decode helpers for the RTC reader.
// Optional BCD frame validation is enabled with the RTC_BCD_CHECK_EN macro.
package rtc_pkg;

    localparam int NUM_REGS = 10;

    localparam logic [7:0] ADDR_SEC   = 8'h21;
    localparam logic [7:0] ADDR_MIN   = 8'h22;
    localparam logic [7:0] ADDR_HOUR  = 8'h23;
    localparam logic [7:0] ADDR_DAY   = 8'h24;
    localparam logic [7:0] ADDR_MONTH = 8'h25;
    localparam logic [7:0] ADDR_YEAR  = 8'h26;
    localparam logic [7:0] ADDR_WDAY  = 8'h27;
    localparam logic [7:0] ADDR_TSEC  = 8'h42;
    localparam logic [7:0] ADDR_TMIN  = 8'h43;
    localparam logic [7:0] ADDR_THOUR = 8'h44;

    localparam logic [7:0] TENS_MASK_SECMIN = 8'h70;
    localparam logic [7:0] TENS_MASK_HOUR24 = 8'h30;
    localparam logic [7:0] TENS_MASK_HOUR12 = 8'h10;
    localparam logic [7:0] TENS_MASK_DAY    = 8'h30;
    localparam logic [7:0] TENS_MASK_MONTH  = 8'h10;
    localparam logic [7:0] TENS_MASK_YEAR   = 8'hF0;
    localparam logic [7:0] TENS_MASK_NONE   = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR_SETUP, ST_ADDR_WR, ST_ADDR_HOLD, ST_DATA_RD, ST_DATA_HOLD, ST_COMMIT
    } rtc_state_e;

    typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_COMMIT} seq_state_e;

    typedef struct packed {
        logic [3:0] ss1, ss0, mm1, mm0, hh1, hh0;
        logic [3:0] dy1, dy0, ms1, ms0, yr1, yr0;
        logic [3:0] st1, st0, mt1, mt0, ht1, ht0;
        logic       am_pm;
        logic [2:0] dia;
    } rtc_disp_t;

    function automatic logic [7:0] reg_addr(input logic [3:0] idx);
        case (idx)
            4'd0:    reg_addr = ADDR_SEC;
            4'd1:    reg_addr = ADDR_MIN;
            4'd2:    reg_addr = ADDR_HOUR;
            4'd3:    reg_addr = ADDR_DAY;
            4'd4:    reg_addr = ADDR_MONTH;
            4'd5:    reg_addr = ADDR_YEAR;
            4'd6:    reg_addr = ADDR_WDAY;
            4'd7:    reg_addr = ADDR_TSEC;
            4'd8:    reg_addr = ADDR_TMIN;
            default: reg_addr = ADDR_THOUR;
        endcase
    endfunction

    // Register 2 is the only one whose tens field depends on the 12/24 h flag.
    function automatic logic bcd_bad(input logic [3:0] idx, input logic [7:0] data);
        logic [7:0] mask;
        logic [7:0] masked;
        logic [3:0] tmax;
        case (idx)
            4'd0, 4'd1, 4'd7, 4'd8: begin mask = TENS_MASK_SECMIN; tmax = 4'd5; end
            4'd2:    begin mask = data[7] ? TENS_MASK_HOUR12 : TENS_MASK_HOUR24; tmax = 4'd2; end
            4'd3:    begin mask = TENS_MASK_DAY;    tmax = 4'd3;  end
            4'd4:    begin mask = TENS_MASK_MONTH;  tmax = 4'd1;  end
            4'd5:    begin mask = TENS_MASK_YEAR;   tmax = 4'd15; end
            4'd9:    begin mask = TENS_MASK_HOUR24; tmax = 4'd2;  end
            default: begin mask = TENS_MASK_NONE;   tmax = 4'd15; end
        endcase
        masked  = data & mask;
        bcd_bad = (data[3:0] > 4'd9) || (masked[7:4] > tmax);
    endfunction

    function automatic rtc_disp_t decode_frame(input logic [NUM_REGS-1:0][7:0] f);
        rtc_disp_t d;
        d.ss0 = f[0][3:0];  d.ss1 = {1'b0, f[0][6:4]};
        d.mm0 = f[1][3:0];  d.mm1 = {1'b0, f[1][6:4]};
        d.hh0 = f[2][3:0];
        if (f[2][7]) begin
            d.hh1   = {3'b000, f[2][4]};
            d.am_pm = f[2][5];
        end else begin
            d.hh1   = {2'b00, f[2][5:4]};
            d.am_pm = 1'b0;
        end
        d.dy0 = f[3][3:0];  d.dy1 = {2'b00, f[3][5:4]};
        d.ms0 = f[4][3:0];  d.ms1 = {3'b000, f[4][4]};
        d.yr0 = f[5][3:0];  d.yr1 = f[5][7:4];
        d.dia = f[6][2:0];
        d.st0 = f[7][3:0];  d.st1 = {1'b0, f[7][6:4]};
        d.mt0 = f[8][3:0];  d.mt1 = {1'b0, f[8][6:4]};
        d.ht0 = f[9][3:0];  d.ht1 = {2'b00, f[9][5:4]};
        return d;
    endfunction

endpackage

// File: rtl/rtc_reader_bus_cycle.sv
// One RTC bus transaction: address write then data read, with start/ack.
// Bus outputs are registered from the next state so they line up with the state.
module rtc_bus_cycle
    import rtc_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 8,
    parameter int T_GAP   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] ad_in_i,
    output logic       ack_o,
    output logic [7:0] rdata_o,
    output logic [7:0] ad_out_o,
    output logic       ad_oe_o,
    output logic       cs_n_o,
    output logic       rd_n_o,
    output logic       wr_n_o,
    output logic       a_d_o
);

    rtc_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q;
    logic [7:0] ad_out_q;
    logic       ad_oe_q, cs_n_q, rd_n_q, wr_n_q, a_d_q;
    logic       addr_ph_s;

    // Phase sequencing; a start seen on the final hold cycle chains the next transaction with no gap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
        addr_d  = addr_q;
        ack_o   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (start_i) begin
                    state_d = ST_ADDR_SETUP;
                    addr_d  = addr_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR_SETUP: begin
                if (cnt_q == 8'(T_SETUP - 1)) begin state_d = ST_ADDR_WR; cnt_d = 8'd0; end
                else begin state_d = ST_ADDR_SETUP; end
            end
            ST_ADDR_WR: begin
                if (cnt_q == 8'(T_PULSE - 1)) begin state_d = ST_ADDR_HOLD; cnt_d = 8'd0; end
                else begin state_d = ST_ADDR_WR; end
            end
            ST_ADDR_HOLD: begin
                if (cnt_q == 8'(T_GAP - 1)) begin state_d = ST_DATA_RD; cnt_d = 8'd0; end
                else begin state_d = ST_ADDR_HOLD; end
            end
            ST_DATA_RD: begin
                if (cnt_q == 8'(T_PULSE - 1)) begin state_d = ST_DATA_HOLD; cnt_d = 8'd0; end
                else begin state_d = ST_DATA_RD; end
            end
            ST_DATA_HOLD: begin
                if (cnt_q == 8'(T_GAP - 1)) begin
                    ack_o = 1'b1;
                    cnt_d = 8'd0;
                    if (start_i) begin
                        state_d = ST_ADDR_SETUP;
                        addr_d  = addr_i;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_DATA_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    assign addr_ph_s = (state_d == ST_ADDR_SETUP) || (state_d == ST_ADDR_WR) ||
                       (state_d == ST_ADDR_HOLD);

    // State, counters, sampled byte and registered pad/strobe outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            addr_q   <= 8'd0;
            data_q   <= 8'd0;
            ad_out_q <= 8'd0;
            ad_oe_q  <= 1'b0;
            cs_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            a_d_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            if ((state_q == ST_DATA_RD) && (cnt_q == 8'(T_PULSE - 1))) begin
                data_q <= ad_in_i;
            end
            ad_out_q <= addr_ph_s ? addr_d : 8'd0;
            ad_oe_q  <= addr_ph_s;
            cs_n_q   <= !(addr_ph_s || (state_d == ST_DATA_RD));
            wr_n_q   <= (state_d != ST_ADDR_WR);
            rd_n_q   <= (state_d != ST_DATA_RD);
            a_d_q    <= !((state_d == ST_DATA_RD) || (state_d == ST_DATA_HOLD));
        end
    end

    assign rdata_o  = data_q;
    assign ad_out_o = ad_out_q;
    assign ad_oe_o  = ad_oe_q;
    assign cs_n_o   = cs_n_q;
    assign rd_n_o   = rd_n_q;
    assign wr_n_o   = wr_n_q;
    assign a_d_o    = a_d_q;

endmodule

// File: rtl/rtc_reader.sv
// Sequences the ten RTC register reads, refresh timing and atomic display commit.
// Define RTC_BCD_CHECK_EN to reject frames with malformed BCD and add bcd_err.
module rtc_reader
    import rtc_pkg::*;
#(
    parameter int T_SETUP        = 2,
    parameter int T_PULSE        = 8,
    parameter int T_GAP          = 4,
    parameter int REFRESH_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rd_req,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic [3:0] digit0_HH, digit1_HH, digit0_MM, digit1_MM, digit0_SS, digit1_SS,
    output logic [3:0] digit0_DAY, digit1_DAY, digit0_MES, digit1_MES, digit0_YEAR, digit1_YEAR,
    output logic [3:0] digit0_HH_T, digit1_HH_T, digit0_MM_T, digit1_MM_T, digit0_SS_T, digit1_SS_T,
    output logic       AM_PM,
    output logic [2:0] dia_semana,
    output logic       busy,
    output logic       done
`ifdef RTC_BCD_CHECK_EN
    ,
    output logic       bcd_err
`endif
);

    localparam int RW = $clog2(REFRESH_CYCLES + 1);

    seq_state_e                 seq_q, seq_d;
    logic [3:0]                 idx_q, idx_d;
    logic                       pend_q, pend_d;
    logic [RW-1:0]              refresh_q, refresh_d;
    logic [NUM_REGS-1:0][7:0]   shadow_q, shadow_d;
    rtc_disp_t                  disp_q;
    logic                       busy_q, done_q;
    logic                       refresh_hit_s, trig_s, start_s, ack_s, commit_s, frame_ok_s;
    logic [7:0]                 addr_s, rdata_s;

    rtc_bus_cycle #(.T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_GAP(T_GAP)) u_bus (
        .clk(clk), .reset(reset), .start_i(start_s), .addr_i(addr_s), .ad_in_i(ad_in),
        .ack_o(ack_s), .rdata_o(rdata_s), .ad_out_o(ad_out), .ad_oe_o(ad_oe),
        .cs_n_o(cs_n), .rd_n_o(rd_n), .wr_n_o(wr_n), .a_d_o(a_d)
    );

    assign refresh_hit_s = (refresh_q == RW'(REFRESH_CYCLES - 1));
    assign trig_s        = rd_req || refresh_hit_s;

`ifdef RTC_BCD_CHECK_EN
    logic err_q, err_d, bcd_err_q;
`endif

    // Sequencer: chains reads back-to-back and folds triggers seen while busy into one pending flag.
    always_comb begin
        seq_d     = seq_q;
        idx_d     = idx_q;
        pend_d    = pend_q;
        shadow_d  = shadow_q;
        start_s   = 1'b0;
        addr_s    = reg_addr(idx_q);
        refresh_d = refresh_hit_s ? '0 : refresh_q + RW'(1);
`ifdef RTC_BCD_CHECK_EN
        err_d     = err_q;
`endif
        case (seq_q)
            SEQ_IDLE: begin
                if (trig_s || pend_q) begin
                    seq_d   = SEQ_RUN;
                    idx_d   = 4'd0;
                    pend_d  = 1'b0;
                    start_s = 1'b1;
                    addr_s  = reg_addr(4'd0);
`ifdef RTC_BCD_CHECK_EN
                    err_d   = 1'b0;
`endif
                end else begin
                    seq_d = SEQ_IDLE;
                end
            end
            SEQ_RUN: begin
                pend_d = pend_q || trig_s;
                if (ack_s) begin
                    shadow_d[idx_q] = rdata_s;
`ifdef RTC_BCD_CHECK_EN
                    err_d = err_q || bcd_bad(idx_q, rdata_s);
`endif
                    if (idx_q == 4'(NUM_REGS - 1)) begin
                        seq_d = SEQ_COMMIT;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        start_s = 1'b1;
                        addr_s  = reg_addr(idx_q + 4'd1);
                    end
                end else begin
                    seq_d = SEQ_RUN;
                end
            end
            SEQ_COMMIT: begin
                pend_d = pend_q || trig_s;
                seq_d  = SEQ_IDLE;
            end
            default: begin
                seq_d = SEQ_IDLE;
            end
        endcase
    end

    assign commit_s = (seq_q == SEQ_RUN) && (seq_d == SEQ_COMMIT);
`ifdef RTC_BCD_CHECK_EN
    assign frame_ok_s = !err_d;
`else
    assign frame_ok_s = 1'b1;
`endif

    // Sequencer state and the committed display registers, decoded from the frame including its last byte.
    always_ff @(posedge clk) begin
        if (!reset) begin
            seq_q     <= SEQ_IDLE;
            idx_q     <= 4'd0;
            pend_q    <= 1'b0;
            refresh_q <= '0;
            shadow_q  <= '0;
            disp_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef RTC_BCD_CHECK_EN
            err_q     <= 1'b0;
            bcd_err_q <= 1'b0;
`endif
        end else begin
            seq_q     <= seq_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            refresh_q <= refresh_d;
            shadow_q  <= shadow_d;
            busy_q    <= (seq_d != SEQ_IDLE);
            done_q    <= commit_s && frame_ok_s;
            if (commit_s && frame_ok_s) begin
                disp_q <= decode_frame(shadow_d);
            end
`ifdef RTC_BCD_CHECK_EN
            err_q     <= err_d;
            bcd_err_q <= commit_s && !frame_ok_s;
`endif
        end
    end

`ifdef RTC_BCD_CHECK_EN
    assign bcd_err = bcd_err_q;
`endif

    assign busy        = busy_q;
    assign done        = done_q;
    assign digit1_SS   = disp_q.ss1;  assign digit0_SS   = disp_q.ss0;
    assign digit1_MM   = disp_q.mm1;  assign digit0_MM   = disp_q.mm0;
    assign digit1_HH   = disp_q.hh1;  assign digit0_HH   = disp_q.hh0;
    assign digit1_DAY  = disp_q.dy1;  assign digit0_DAY  = disp_q.dy0;
    assign digit1_MES  = disp_q.ms1;  assign digit0_MES  = disp_q.ms0;
    assign digit1_YEAR = disp_q.yr1;  assign digit0_YEAR = disp_q.yr0;
    assign digit1_SS_T = disp_q.st1;  assign digit0_SS_T = disp_q.st0;
    assign digit1_MM_T = disp_q.mt1;  assign digit0_MM_T = disp_q.mt0;
    assign digit1_HH_T = disp_q.ht1;  assign digit0_HH_T = disp_q.ht0;
    assign AM_PM       = disp_q.am_pm;
    assign dia_semana  = disp_q.dia;

endmodule

// File: tb/tb_rtc_reader.sv
// Scoreboard bench for rtc_reader with a behavioural RTC register file on the bus.
module tb_rtc_reader;

    typedef struct packed {
        logic [3:0] ss1, ss0, mm1, mm0, hh1, hh0;
        logic [3:0] dy1, dy0, ms1, ms0, yr1, yr0;
        logic [3:0] st1, st0, mt1, mt0, ht1, ht0;
        logic       am_pm;
        logic [2:0] dia;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rd_req = 1'b0;
    logic [7:0] ad_in, ad_out;
    logic ad_oe, cs_n, rd_n, wr_n, a_d, AM_PM, busy, done;
    logic [3:0] d0_hh, d1_hh, d0_mm, d1_mm, d0_ss, d1_ss, d0_dy, d1_dy, d0_ms, d1_ms, d0_yr, d1_yr;
    logic [3:0] d0_ht, d1_ht, d0_mt, d1_mt, d0_st, d1_st;
    logic [2:0] dia_semana;
`ifdef RTC_BCD_CHECK_EN
    logic bcd_err;
    int   bcd_err_cnt = 0;
`endif

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int cyc = 0;
    int busy_len = 0;
    logic busy_prev = 1'b0;
    int done_cyc_q[$];
    exp_t exp_q[$];
    exp_t act_s;

    logic [7:0] rtc_mem [256];
    logic [7:0] addr_latch = 8'h00;
    logic       wr_n_prev = 1'b1;
    logic [7:0] addr_log[$];

    always #5 clk = ~clk;

    rtc_reader dut (
        .clk(clk), .reset(reset), .rd_req(rd_req), .ad_in(ad_in), .ad_out(ad_out),
        .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d),
        .digit0_HH(d0_hh), .digit1_HH(d1_hh), .digit0_MM(d0_mm), .digit1_MM(d1_mm),
        .digit0_SS(d0_ss), .digit1_SS(d1_ss), .digit0_DAY(d0_dy), .digit1_DAY(d1_dy),
        .digit0_MES(d0_ms), .digit1_MES(d1_ms), .digit0_YEAR(d0_yr), .digit1_YEAR(d1_yr),
        .digit0_HH_T(d0_ht), .digit1_HH_T(d1_ht), .digit0_MM_T(d0_mt), .digit1_MM_T(d1_mt),
        .digit0_SS_T(d0_st), .digit1_SS_T(d1_st),
        .AM_PM(AM_PM), .dia_semana(dia_semana), .busy(busy), .done(done)
`ifdef RTC_BCD_CHECK_EN
        , .bcd_err(bcd_err)
`endif
    );

    assign act_s = {d1_ss, d0_ss, d1_mm, d0_mm, d1_hh, d0_hh, d1_dy, d0_dy, d1_ms, d0_ms,
                    d1_yr, d0_yr, d1_st, d0_st, d1_mt, d0_mt, d1_ht, d0_ht, AM_PM, dia_semana};

    // RTC model: latches the address during wr_n low, returns the register while rd_n low.
    assign ad_in = (!cs_n && !rd_n) ? rtc_mem[addr_latch] : 8'hFF;
    always @(posedge clk) begin
        if (!wr_n) addr_latch <= ad_out;
        if (!wr_n && wr_n_prev) addr_log.push_back(ad_out);
        wr_n_prev <= wr_n;
        cyc = cyc + 1;
    end

    // Monitor: every done pulse pops one expected frame and checks the busy window length.
    always @(negedge clk) begin
        if (busy) busy_len = busy_prev ? busy_len + 1 : 1;
        busy_prev = busy;
`ifdef RTC_BCD_CHECK_EN
        if (bcd_err) bcd_err_cnt++;
`endif
        if (done) begin
            done_cnt++;
            done_cyc_q.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done act=%h exp=none", act_s);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (act_s !== e) begin
                    failures++;
                    $display("FAIL frame_digits act=%h exp=%h", act_s, e);
                end
            end
            checks++;
            if (busy_len != 261) begin
                failures++;
                $display("FAIL busy_len act=%0d exp=261", busy_len);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic set_regs(input logic [79:0] v);
        logic [7:0] addrs [10];
        addrs = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h42, 8'h43, 8'h44};
        for (int i = 0; i < 10; i++) rtc_mem[addrs[i]] = v[79 - 8*i -: 8];
    endtask

    task automatic pulse_req();
        rd_req = 1'b1;
        tick(1);
        rd_req = 1'b0;
    endtask

    task automatic wait_dones(input int target, input int bound);
        int n = 0;
        while (done_cnt < target && n < bound) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (done_cnt < target) begin
            checks++;
            failures++;
            $display("FAIL done_timeout act=%0d exp=%0d", done_cnt, target);
        end
    endtask

    // Register images are listed sec, min, hour, day, month, year, weekday, T_sec, T_min, T_hour.
    localparam logic [79:0] REGS_A = 80'h59_34_23_31_12_24_03_07_45_19;
    localparam logic [79:0] REGS_B = 80'h00_07_B1_09_01_99_05_59_00_23;
    localparam logic [79:0] REGS_C = 80'hC1_18_92_E8_70_07_06_30_51_08;
    localparam logic [79:0] REGS_D = 80'h11_11_11_11_11_11_01_11_11_11;
    localparam exp_t EXP_A = {4'd5,4'd9, 4'd3,4'd4, 4'd2,4'd3, 4'd3,4'd1, 4'd1,4'd2, 4'd2,4'd4,
                              4'd0,4'd7, 4'd4,4'd5, 4'd1,4'd9, 1'b0, 3'd3};
    localparam exp_t EXP_B = {4'd0,4'd0, 4'd0,4'd7, 4'd1,4'd1, 4'd0,4'd9, 4'd0,4'd1, 4'd9,4'd9,
                              4'd5,4'd9, 4'd0,4'd0, 4'd2,4'd3, 1'b1, 3'd5};
    localparam exp_t EXP_C = {4'd4,4'd1, 4'd1,4'd8, 4'd1,4'd2, 4'd2,4'd8, 4'd1,4'd0, 4'd0,4'd7,
                              4'd3,4'd0, 4'd5,4'd1, 4'd0,4'd8, 1'b0, 3'd6};

    initial begin
        logic [7:0] want_addr [10];
        int found;
        want_addr = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h42, 8'h43, 8'h44};
        for (int i = 0; i < 256; i++) rtc_mem[i] = 8'h00;

        reset = 1'b0;
        tick(3);
        chk("rst_digits", 80'(act_s), 80'd0);
        chk("rst_strobes", 80'({cs_n, rd_n, wr_n, a_d, ad_oe}), 80'(5'b11110));
        chk("rst_busy_done", 80'({busy, done}), 80'd0);
        chk("rst_ad_out", 80'(ad_out), 80'd0);
        reset = 1'b1;
        tick(2);

        set_regs(REGS_A);
        addr_log.delete();
        exp_q.push_back(EXP_A);
        pulse_req();
        wait_dones(1, 400);
        tick(2);
        chk("a_busy_after", 80'(busy), 80'd0);
        chk("addr_count", 80'(addr_log.size()), 80'd10);
        for (int i = 0; i < 10 && i < addr_log.size(); i++)
            chk($sformatf("addr_order_%0d", i), 80'(addr_log[i]), 80'(want_addr[i]));

        set_regs(REGS_B);
        exp_q.push_back(EXP_B);
        pulse_req();
        wait_dones(2, 400);
        tick(2);
        chk("b_am_pm", 80'(AM_PM), 80'd1);
        chk("b_weekday", 80'(dia_semana), 80'd5);
        chk("b_hh", 80'({d1_hh, d0_hh}), 80'h11);

        set_regs(REGS_C);
        exp_q.push_back(EXP_C);
        exp_q.push_back(EXP_C);
        pulse_req();
        tick(20);
        pulse_req();
        tick(20);
        pulse_req();
        wait_dones(4, 800);
        tick(400);
        chk("done_total", 80'(done_cnt), 80'd4);
        if (done_cyc_q.size() >= 4)
            chk("rerun_gap", 80'(done_cyc_q[3] - done_cyc_q[2]), 80'd262);
        else
            chk("rerun_gap_count", 80'(done_cyc_q.size()), 80'd4);

        set_regs(REGS_D);
        addr_log.delete();
        pulse_req();
        found = 0;
        for (int n = 0; n < 400 && found == 0; n++) begin
            tick(1);
            if (addr_log.size() > 0 && addr_log[addr_log.size()-1] == 8'h24 && !rd_n) found = 1;
        end
        chk("abort_reached_rd", 80'(found), 80'd1);
        tick(3);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        chk("abort_bus_idle", 80'({cs_n, rd_n, wr_n, a_d, ad_oe, ad_out}), 80'({5'b11110, 8'h00}));
        chk("abort_busy", 80'(busy), 80'd0);
        chk("abort_digits", 80'(act_s), 80'd0);
        tick(400);
        chk("abort_no_done", 80'(done_cnt), 80'd4);

`ifdef RTC_BCD_CHECK_EN
        set_regs(REGS_A);
        exp_q.push_back(EXP_A);
        pulse_req();
        wait_dones(5, 400);
        rtc_mem[8'h21] = 8'h5A;
        pulse_req();
        tick(300);
        chk("bcd_err_pulses", 80'(bcd_err_cnt), 80'd1);
        chk("bcd_no_done", 80'(done_cnt), 80'd5);
        chk("bcd_digits_kept", 80'(act_s), 80'(EXP_A));
`endif

        chk("scoreboard_empty", 80'(exp_q.size()), 80'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtc_reader.md
Name: rtc_reader

Overview:
- Periodically reads time, date, weekday and timer registers from the external RTC over its multiplexed address/data bus.
- Converts the register contents into the BCD digit, AM_PM and dia_semana signals that the VGA clock-screen top consumes.
- Is the source end of that digit interface: the screen is the reader, this block is the writer.
- All outputs update atomically from shadow registers, so the display never shows a partially updated frame.

Parameters:
- T_SETUP, 2: cycles with address driven before the wr_n strobe.
- T_PULSE, 8: width in cycles of each wr_n or rd_n strobe.
- T_GAP, 4: cycles of hold/recovery after each strobe.
- REFRESH_CYCLES, 10_000_000: cycles between automatic read sequences (100 ms at 100 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- rd_req  in  1  single-cycle pulse requesting an immediate read sequence.
- ad_in  in  8  RTC bus data in (from the tristate pad).
- ad_out  out  8  RTC bus data out.
- ad_oe  out  1  enable for the ad_out pad driver.
- cs_n, rd_n, wr_n  out  1 each  RTC strobes, active-low.
- a_d  out  1  1 = address phase, 0 = data phase.
- digit0_*/digit1_* for HH, MM, SS, DAY, MES, YEAR, HH_T, MM_T, SS_T  out  4 each  units/tens BCD.
- AM_PM  out  1  1 = PM.
- dia_semana  out  3  weekday.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse when the outputs have been committed.

Behaviour:
- Reset (reset = 0 at a clk edge): cs_n = rd_n = wr_n = 1, a_d = 1, ad_oe = 0, ad_out = 0. All digits, AM_PM and dia_semana = 0. busy = done = 0. Refresh counter and pending flag = 0.
- Reset mid-sequence: the sequence aborts, the bus returns to idle on the next cycle, and shadow registers are discarded.
- Triggers:
  - rd_req, or the refresh counter reaching REFRESH_CYCLES-1; the counter then wraps to 0.
  - A trigger while busy sets a single pending flag; further triggers are merged into it.
  - A pending flag starts a new sequence from IDLE on the cycle after COMMIT.
- Register order (fixed): 0x21 sec, 0x22 min, 0x23 hour, 0x24 day, 0x25 month, 0x26 year, 0x27 weekday, 0x42 T_sec, 0x43 T_min, 0x44 T_hour.
- FSM states: IDLE, ADDR_SETUP, ADDR_WR, ADDR_HOLD, DATA_RD, DATA_HOLD, COMMIT.
  - ADDR_SETUP (T_SETUP cycles): cs_n = 0, a_d = 1, ad_oe = 1, ad_out = address.
  - ADDR_WR (T_PULSE cycles): as ADDR_SETUP, plus wr_n = 0.
  - ADDR_HOLD (T_GAP cycles): wr_n = 1, address still driven.
  - DATA_RD (T_PULSE cycles): a_d = 0, ad_oe = 0, rd_n = 0. ad_in is sampled into the shadow register on the last cycle.
  - DATA_HOLD (T_GAP cycles): cs_n = rd_n = 1. Then go to the next register, or to COMMIT after 0x44.
  - COMMIT (1 cycle): shadow values are copied to the outputs and done = 1.
- busy is high from the first ADDR_SETUP cycle through COMMIT: exactly 10*(T_SETUP+2*T_PULSE+2*T_GAP)+1 cycles, which is 261 with the defaults.
- Decoding: digit0 = data[3:0] and digit1 = tens field.
  - Tens fields: sec/min [6:4]; day [5:4]; month [4]; year [7:4].
  - Hours:
    - If bit7 = 1 (12 h): digit1_HH = {3'b0, data[4]} and AM_PM = data[5].
    - Otherwise (24 h): digit1_HH = data[5:4] and AM_PM = 0.
  - Timer hours are always treated as 24 h.
  - dia_semana = weekday data[2:0].
- Outputs hold their last committed value between sequences.

Optional Feature:
- Macro RTC_BCD_CHECK_EN.
- Defined:
  - Any sampled units nibble > 9, or any tens field out of range (sec/min > 5, hour-24 > 2, day > 3, month > 1), marks the frame invalid.
  - An invalid frame still reaches COMMIT, but outputs are not updated and done stays 0.
  - An extra output bcd_err (1 bit, reset 0) pulses in COMMIT.
- Undefined: no checking, no bcd_err port, and every frame commits.

Decomposition:
- Package rtc_pkg: register address constants, FSM state encoding, register count (10), per-register tens-mask constants.
- One natural sub-module: rtc_bus_cycle. It performs a single address-write plus data-read transaction with start/ack, owns the strobe timing counters, and returns the sampled byte.
- rtc_reader keeps the sequencing, refresh counter, shadow registers and decode.

Test Plan:
- Reset: hold reset = 0 for 3 cycles → all outputs 0, cs_n = rd_n = wr_n = 1, ad_oe = 0, busy = 0.
- 24 h read: RTC model returns sec = 0x59, min = 0x34, hour = 0x23; pulse rd_req.
  - Expect digit1_SS = 5, digit0_SS = 9, digit1_MM = 3, digit0_MM = 4, digit1_HH = 2, digit0_HH = 3, AM_PM = 0.
  - Expect done exactly 261 cycles after busy rises.
- 12 h read: hour = 0xB1, weekday = 0x05 → digit1_HH = 1, digit0_HH = 1, AM_PM = 1, dia_semana = 5.
- rd_req pulsed twice during busy → exactly one extra sequence, starting the cycle after COMMIT; two done pulses total.
- reset = 0 asserted while DATA_RD of 0x24 → bus idle next cycle; outputs 0; no done pulse.
- With RTC_BCD_CHECK_EN: sec = 0x5A → bcd_err pulses, done = 0, previously committed digits unchanged.
